pipe_collision_score: RTL and testbench

Per-frame game-rule stage that consumes the pipe position produced by the pipe mover and the bird position, detects collisions, counts passed pipes and sequences the game through idle/play/hit/over. Its score output feeds back to the pipe mover's score input (speed and respawn spacing) and to the HUD; its freeze flag gates the movers. Everything advances on frame_clk, so one cycle equals one video frame.

---
 rtl/pipe_collision_score.sv | 124 ++++++++++++
 tb/tb_pipe_collision_score.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_collision_score.sv
// pipe_collision_score
//   Per-frame game-rule stage. Detects bird/pipe and bird/ground collisions,
//   counts pipes the bird has passed, and sequences the game through
//   IDLE -> PLAY -> HIT -> OVER -> IDLE. One frame_clk cycle is one frame.
//
// Ports
//   frame_clk  in   frame clock, all state updates on its rising edge
//   Reset      in   asynchronous active-high clear
//   keycode    in   current USB keycode (0 = no key)
//   BirdX/Y    in   bird centre; BirdS in: bird half-size
//   PipeX/Y    in   pipe column centre X, gap centre Y
//   score      out  passed-pipe count (saturating)
//   playing    out  state == PLAY
//   freeze     out  state != PLAY (movers hold)
//   game_over  out  state == OVER
//   state      out  IDLE=0, PLAY=1, HIT=2, OVER=3
module pipe_collision_score #(
  parameter int unsigned PIPE_HALF_W = 26,
  parameter int unsigned GAP_HALF    = 60,
  parameter int unsigned GROUND_Y    = 440,
  parameter int unsigned HIT_FRAMES  = 30,
  parameter logic [7:0]  START_KEY   = 8'h1A,
  parameter logic [7:0]  RESTART_KEY = 8'h15
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [7:0]  keycode,
  input  logic [9:0]  BirdX,
  input  logic [9:0]  BirdY,
  input  logic [9:0]  BirdS,
  input  logic [9:0]  PipeX,
  input  logic [9:0]  PipeY,
  output logic [26:0] score,
  output logic        playing,
  output logic        freeze,
  output logic        game_over,
  output logic [1:0]  state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] HIT  = 2'd2;
  localparam logic [1:0] OVER = 2'd3;

  localparam logic [10:0] PHW = 11'(PIPE_HALF_W);
  localparam logic [10:0] GH  = 11'(GAP_HALF);
  localparam logic [10:0] GY  = 11'(GROUND_Y);
  localparam logic [7:0]  HIT_LOAD = 8'(HIT_FRAMES - 1);

  logic [7:0]  hit_timer;
  logic [9:0]  prev_pipe_x;
  logic        armed;

  logic [10:0] bx, by, bs, px, py;
  logic        x_overlap, gap_miss, ground, collide, pass;

  assign bx = {1'b0, BirdX};
  assign by = {1'b0, BirdY};
  assign bs = {1'b0, BirdS};
  assign px = {1'b0, PipeX};
  assign py = {1'b0, PipeY};

  // Every difference is moved to the other side as a sum, so no term can
  // underflow near the screen edges.
  always_comb begin
    x_overlap = ((bx + bs + PHW) >= px) && ((px + PHW + bs) >= bx);
    gap_miss  = ((by + GH) < (py + bs)) || ((by + bs) > (py + GH));
    ground    = (by + bs) >= GY;
    collide   = (x_overlap && gap_miss) || ground;
    // Only a leftward move that carries the pipe across BirdX counts;
    // a respawn jump to the right never does.
    pass      = (prev_pipe_x > BirdX) && (PipeX <= BirdX) && (PipeX < prev_pipe_x);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      score       <= '0;
      hit_timer   <= '0;
      prev_pipe_x <= '0;
      armed       <= 1'b0;
    end else begin
      prev_pipe_x <= PipeX;
      case (state)
        IDLE: begin
          score <= '0;
          if (keycode == START_KEY) state <= PLAY;
        end
        PLAY: begin
          if (collide) begin
            state     <= HIT;
            hit_timer <= HIT_LOAD;
          end else if (pass && (score != '1)) begin
            score <= score + 27'd1;
          end
        end
        HIT: begin
          if (hit_timer == '0) begin
            state <= OVER;
            armed <= 1'b0;
          end else begin
            hit_timer <= hit_timer - 8'd1;
          end
        end
        OVER: begin
          // A key release is required before restart, so a key held
          // through the HIT sequence cannot restart the game.
          if (keycode == 8'h00) begin
            armed <= 1'b1;
          end else if (armed && (keycode == RESTART_KEY)) begin
            state <= IDLE;
            score <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign playing   = (state == PLAY);
  assign freeze    = (state != PLAY);
  assign game_over = (state == OVER);

endmodule

// File: tb/tb_pipe_collision_score.sv
module tb_pipe_collision_score;

  localparam int      HALF_W  = 26;
  localparam int      GAPH    = 60;
  localparam int      GROUNDY = 440;
  localparam int      HITF    = 30;
  localparam longint  SMAX    = (64'd1 << 27) - 1;

  logic        frame_clk = 1'b0;
  logic        Reset     = 1'b1;
  logic [7:0]  keycode   = 8'h00;
  logic [9:0]  BirdX = 10'd200, BirdY = 10'd240, BirdS = 10'd4;
  logic [9:0]  PipeX = 10'd700, PipeY = 10'd240;
  logic [26:0] score;
  logic        playing, freeze, game_over;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  pipe_collision_score #(
    .PIPE_HALF_W(26), .GAP_HALF(60), .GROUND_Y(440), .HIT_FRAMES(30),
    .START_KEY(8'h1A), .RESTART_KEY(8'h15)
  ) dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
    .BirdX(BirdX), .BirdY(BirdY), .BirdS(BirdS),
    .PipeX(PipeX), .PipeY(PipeY),
    .score(score), .playing(playing), .freeze(freeze),
    .game_over(game_over), .state(state)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic [7:0] key;
    int bx, by, bs, px, py;
    int exp_state;
    longint exp_score;
  } vec_t;

  vec_t tbl[11];

  // Behavioural reference: game rules expressed with signed integer geometry.
  int     m_state, m_hitcnt, m_prev, m_armed;
  longint m_score;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int es, input longint esc);
    chk({tag, " state"}, longint'(state), longint'(es));
    chk({tag, " score"}, longint'(score), esc);
    chk({tag, " playing"}, longint'(playing), longint'(es == 1));
    chk({tag, " freeze"}, longint'(freeze), longint'(es != 1));
    chk({tag, " game_over"}, longint'(game_over), longint'(es == 3));
  endtask

  task automatic drive(input logic [7:0] k, input int bx, input int by, input int bs,
                       input int px, input int py);
    @(negedge frame_clk);
    keycode = k;
    BirdX = 10'(bx); BirdY = 10'(by); BirdS = 10'(bs);
    PipeX = 10'(px); PipeY = 10'(py);
    @(posedge frame_clk);
    #1;
  endtask

  task automatic model_reset();
    m_state = 0; m_hitcnt = 0; m_prev = 0; m_armed = 0; m_score = 0;
  endtask

  task automatic model_edge(input logic [7:0] k, input int bx, input int by, input int bs,
                            input int px, input int py);
    bit xo, miss, gnd, coll, passed;
    xo     = (px - bx <= bs + HALF_W) && (bx - px <= bs + HALF_W);
    miss   = (by - bs < py - GAPH) || (by + bs > py + GAPH);
    gnd    = (by + bs >= GROUNDY);
    coll   = (xo && miss) || gnd;
    passed = (m_prev > bx) && (px <= bx) && (px < m_prev);
    case (m_state)
      0: begin
        m_score = 0;
        if (k == 8'h1A) m_state = 1;
      end
      1: begin
        if (coll) begin
          m_state = 2; m_hitcnt = 0;
        end else if (passed && m_score < SMAX) begin
          m_score = m_score + 1;
        end
      end
      2: begin
        m_hitcnt = m_hitcnt + 1;
        if (m_hitcnt == HITF) begin
          m_state = 3; m_armed = 0;
        end
      end
      default: begin
        if (k == 8'h00) m_armed = 1;
        else if (m_armed != 0 && k == 8'h15) begin
          m_state = 0; m_score = 0;
        end
      end
    endcase
    m_prev = px;
  endtask

  task automatic do_reset();
    @(negedge frame_clk);
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{8'h00, 200, 240, 4, 700, 240, 0, 0};
    tbl[1]  = '{8'h1A, 200, 240, 4, 700, 240, 1, 0};
    tbl[2]  = '{8'h00, 200, 240, 4, 203, 240, 1, 0};
    tbl[3]  = '{8'h00, 200, 240, 4, 202, 240, 1, 0};
    tbl[4]  = '{8'h00, 200, 240, 4, 201, 240, 1, 0};
    tbl[5]  = '{8'h00, 200, 240, 4, 200, 240, 1, 1};
    tbl[6]  = '{8'h00, 200, 240, 4, 199, 240, 1, 1};
    tbl[7]  = '{8'h1A, 200, 240, 4,   0, 240, 1, 1};
    tbl[8]  = '{8'h00, 200, 240, 4, 700, 240, 1, 1};
    tbl[9]  = '{8'h00, 200, 240, 4, 210, 240, 1, 1};
    // collision and pass in the same frame: collision wins
    tbl[10] = '{8'h00, 200, 230, 4, 200, 300, 2, 1};

    #3;
    check_outs("reset", 0, 0);
    @(negedge frame_clk);
    Reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].key, tbl[i].bx, tbl[i].by, tbl[i].bs, tbl[i].px, tbl[i].py);
      check_outs($sformatf("vec%0d", i), tbl[i].exp_state, tbl[i].exp_score);
    end

    // HIT lasts HITF edges, restart key held throughout
    for (int i = 1; i <= HITF; i++) begin
      drive(8'h15, 200, 230, 4, 200, 300);
      check_outs($sformatf("hit%0d", i), (i == HITF) ? 3 : 2, 1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(8'h15, 200, 240, 4, 700, 240);
      check_outs("held_restart", 3, 1);
    end
    drive(8'h1A, 200, 240, 4, 700, 240);
    check_outs("start_in_over", 3, 1);
    drive(8'h00, 200, 240, 4, 700, 240);
    check_outs("arm", 3, 1);
    drive(8'h15, 200, 240, 4, 700, 240);
    check_outs("restart", 0, 0);

    // ground boundary
    drive(8'h1A, 200, 240, 4, 700, 240);
    check_outs("start2", 1, 0);
    drive(8'h00, 200, 435, 4, 700, 240);
    check_outs("ground_439", 1, 0);
    drive(8'h00, 200, 436, 4, 700, 240);
    check_outs("ground_440", 2, 0);

    // saturation, then asynchronous reset in HIT
    do_reset();
    drive(8'h1A, 200, 240, 4, 700, 240);
    check_outs("start3", 1, 0);
    drive(8'h00, 200, 240, 4, 201, 240);
    check_outs("pre_sat", 1, 0);
    @(negedge frame_clk);
    force dut.score = 27'h7FF_FFFF;
    #1;
    release dut.score;
    #1;
    chk("preset_score", longint'(score), SMAX);
    PipeX = 10'd200;
    @(posedge frame_clk);
    #1;
    check_outs("sat_pass", 1, SMAX);
    drive(8'h00, 200, 436, 4, 700, 240);
    check_outs("sat_hit", 2, SMAX);
    drive(8'h00, 200, 240, 4, 700, 240);
    check_outs("sat_hit2", 2, SMAX);
    @(negedge frame_clk);
    Reset = 1'b1;
    #1;
    check_outs("async_reset", 0, 0);
    #1;
    Reset = 1'b0;

    // randomized play against the reference model
    do_reset();
    model_reset();
    begin
      int pipe_pos = 650;
      for (int n = 0; n < 3000; n++) begin
        int r, bx, by, bs, py;
        logic [7:0] k;
        r = int'($urandom_range(0, 9));
        if (r < 4) k = 8'h00;
        else if (r < 6) k = 8'h1A;
        else if (r < 8) k = 8'h15;
        else if (r == 8) k = 8'h04;
        else k = 8'($urandom);
        bx = int'($urandom_range(150, 250));
        by = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 450))
                                         : int'($urandom_range(190, 290));
        bs = int'($urandom_range(2, 10));
        py = int'($urandom_range(180, 300));
        pipe_pos = pipe_pos - int'($urandom_range(1, 3));
        if (pipe_pos < 5) pipe_pos = int'($urandom_range(600, 700));
        model_edge(k, bx, by, bs, pipe_pos, py);
        drive(k, bx, by, bs, pipe_pos, py);
        check_outs($sformatf("rand%0d", n), m_state, m_score);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
